mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one single-ported unified memory between the processor's instruction-fetch port and its data load/store port. Each requester uses a level request / one-cycle acknowledge handshake. The arbiter grants one access at a time, holds the memory interface for a fixed access latency, and registers the read data. It also produces a stall signal that gates the program-counter enable while a fetch or data access is outstanding.

## Interface
- MEM_LAT, 2, memory access cycles per transaction; legal range 1..15
- AW, 32, address width
- DW, 32, data width

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (0 = reset)
- if_req  in  1  fetch request, level; held until if_ack
- if_addr  in  AW  fetch address; stable while if_req is high
- if_rdata  out  DW  registered fetch data
- if_ack  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request, level; held until d_ack
- d_we  in  1  1 = store, 0 = load; stable while d_req is high
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  registered load data
- d_ack  out  1  one-cycle data completion pulse
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid in the last ACCESS cycle
- stall  out  1  (if_req & ~if_ack) | (d_req & ~d_ack), combinational
- busy  out  1  1 when the FSM is not in IDLE

## Operation
**FSM states:** IDLE, ACCESS, DONE.

**IDLE**
- With no request pending, the FSM stays in IDLE.
- With any request pending, the FSM selects a winner and moves to ACCESS.
- On entry to ACCESS it latches the winner ID, address, write enable and write data into the mem_* registers, and clears cnt.

**ACCESS**
- mem_en = 1 for every ACCESS cycle.
- mem_we = the latched d_we when the data port won; 0 for a fetch.
- cnt increments every cycle.
- When cnt == MEM_LAT-1:
  - on a read, mem_rdata is captured into the winner's rdata register;
  - the FSM moves to DONE.

**DONE**
- The winner's ack = 1 for this single cycle.
- mem_en = 0 and mem_we = 0.
- The FSM always returns to IDLE.

**Read data**
- if_rdata and d_rdata each hold their value until the next read on the same port.
- A store leaves d_rdata unchanged.

**Arbitration**
- Arbitration is evaluated only in IDLE.
- If only one request is pending, that requester wins.
- If both are pending, the winner depends on the Configuration section.

**Requester rule:** the requester deasserts req on the edge that ends the ack cycle, unless it has a new request ready. A req that is still high in IDLE is treated as a new request.

**Reset values:** state = IDLE, cnt = 0, all ack/mem_en/mem_we = 0, mem_addr/mem_wdata/if_rdata/d_rdata = 0, last-winner pointer = fetch.

**Reset mid-operation:** the access is aborted and no ack is issued.
- mem_en drops in the cycle after the reset edge.
- A partially completed store is undefined in memory. The requester re-issues it.

**Width rule:** cnt is 4 bits. MEM_LAT outside 1..15 is a compile-time error.

## Timing
- Request sampled high at IDLE edge E0.
- ACCESS occupies cycles E0+1 .. E0+MEM_LAT.
- ack is high in cycle E0+MEM_LAT+1; rdata is valid from that same cycle.
- FSM is back in IDLE at E0+MEM_LAT+2.
- Throughput: one transaction every MEM_LAT+2 cycles.
- stall is high from req assertion until the ack cycle inclusive of the combinational drop, i.e. low in the ack cycle for a sole requester.
- A request arriving during ACCESS/DONE waits; it is sampled in the next IDLE cycle.
- A new request on the same port in the cycle after ack competes normally in that IDLE cycle.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a simultaneous request, the port that did not win last gets the grant. The last-winner pointer updates on every grant.
- Undefined: fixed priority, data port always wins over fetch. The pointer register is not built.

## Test plan
- MEM_LAT=2, only if_req with if_addr=0x10 and mem_rdata=0xDEADBEEF → mem_en high two cycles with mem_addr=0x10; if_ack pulses at E0+3; if_rdata=0xDEADBEEF.
- Store: d_req, d_we=1, d_addr=0x40, d_wdata=0x1234 → mem_we=1 for MEM_LAT cycles; d_ack pulse; d_rdata unchanged.
- Both requests held continuously for 4 transactions → with ARB_ROUND_ROBIN_EN the grant order is D, I, D, I; without it D, D, D, D and if_ack never fires.
- Back-to-back data reads with req held across ack → second transaction starts one IDLE cycle after DONE; acks 4 cycles apart at MEM_LAT=2.
- reset=0 asserted in the second ACCESS cycle → no ack; mem_en=0 next cycle; all outputs at reset values; request re-served normally after release.
- MEM_LAT=1 with a sole fetch → ack two cycles after sampling; stall high only in the cycles before the ack cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-ported unified memory
//
// Shares one single-ported memory between the instruction-fetch port and the
// data load/store port. Each requester holds a level request until it sees a
// one-cycle acknowledge. One access runs at a time and keeps the memory
// strobes up for MEM_LAT cycles. Read data is registered per port.
//
// Optional build macro: ARB_ROUND_ROBIN_EN
//   defined   - when both ports request together, the port that did not win
//               the previous grant wins this one
//   undefined - fixed priority: the data port always wins over fetch
//
// Parameters: MEM_LAT (1..15 access cycles), AW (address width), DW (data width)
// Ports:
//   clk, reset                  clock, synchronous active-low reset
//   if_req/if_addr              fetch request (level) and address
//   if_rdata/if_ack             registered fetch data, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata   data request, store enable, address, store data
//   d_rdata/d_ack               registered load data, one-cycle completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory interface
//   stall                       holds the PC while an access is outstanding
//   busy                        arbiter FSM is not idle

`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall,
    output logic          busy
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_mem_lat_range
        $error("mem_port_arbiter: MEM_LAT must be within 1..15");
    end

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          win_d_q;      // 1 = data port owns the current access
    logic          if_ack_q;
    logic          d_ack_q;
    logic          mem_en_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          grant_d_d;    // data port wins if arbitration happens this cycle

`ifdef ARB_ROUND_ROBIN_EN
    logic          last_d_q;     // 1 = data port won the previous grant

    // On a tie the port that did not win last time goes first.
    always_comb begin
        grant_d_d = d_req & (~if_req | ~last_d_q);
    end
`else
    always_comb begin
        grant_d_d = d_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            win_d_q     <= 1'b0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            // Acks are single-cycle pulses raised only on the ACCESS->DONE edge.
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (if_req || d_req) begin
                        state_q    <= S_ACCESS;
                        cnt_q      <= 4'd0;
                        win_d_q    <= grant_d_d;
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= grant_d_d & d_we;
                        mem_addr_q <= grant_d_d ? d_addr : if_addr;
                        if (grant_d_d) begin
                            mem_wdata_q <= d_wdata;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last_d_q   <= grant_d_d;
`endif
                    end
                end
                S_ACCESS: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == LAT_M1) begin
                        state_q  <= S_DONE;
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        // mem_we_q still reflects the access being finished here.
                        if (!mem_we_q) begin
                            if (win_d_q) begin
                                d_rdata_q <= mem_rdata;
                            end else begin
                                if_rdata_q <= mem_rdata;
                            end
                        end
                        if (win_d_q) begin
                            d_ack_q <= 1'b1;
                        end else begin
                            if_ack_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != S_IDLE);
    assign stall     = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);

endmodule
